// File: rtl/ula_seq_adder.sv
// ula_seq_adder: multi-cycle signed adder/subtractor.
// Both operands are sign-extended to OUT_WIDTH and summed CHUNK bits per
// clock over a registered carry chain. The result and the sign/zero/carry
// flags are presented behind a valid/ready handshake.
// Optional macro ULA_SEQ_ACC_EN adds an in_acc port. When in_acc is set,
// operand A is replaced by the last completed result.
// Assumes NCHUNK >= 2 (OUT_WIDTH >= 2*CHUNK).
module ula_seq_adder #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16,
  parameter int CHUNK     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  a,
  input  logic [IN_WIDTH-1:0]  b,
  input  logic                 operation,
`ifdef ULA_SEQ_ACC_EN
  input  logic                 in_acc,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 sign_flag,
  output logic                 zero_flag,
  output logic                 carry_flag
);

  localparam int NCHUNK = OUT_WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   a_q, b_q, sum_q;
  logic                   carry_q;
  logic [IDXW-1:0]        idx_q;
  logic [OUT_WIDTH-1:0]   result_q;
  logic                   sign_q, zero_q, cflag_q;
`ifdef ULA_SEQ_ACC_EN
  logic [OUT_WIDTH-1:0]   last_q;
`endif

  logic [OUT_WIDTH-1:0]   a_ext, b_ext, a_src;
  logic [CHUNK:0]         csum;
  logic [OUT_WIDTH-1:0]   sum_nxt;
  logic                   accept, last_chunk;

  // Operand extension, operand A source selection, and the per-cycle chunk adder
  always_comb begin
    a_ext = {{(OUT_WIDTH-IN_WIDTH){a[IN_WIDTH-1]}}, a};
    b_ext = {{(OUT_WIDTH-IN_WIDTH){b[IN_WIDTH-1]}}, b};
`ifdef ULA_SEQ_ACC_EN
    a_src = in_acc ? last_q : a_ext;
`else
    a_src = a_ext;
`endif
    csum = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
         + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
         + {{CHUNK{1'b0}}, carry_q};
    // New chunk enters at the top, so after NCHUNK shifts chunk 0 sits at bit 0
    sum_nxt    = {csum[CHUNK-1:0], sum_q[OUT_WIDTH-1:CHUNK]};
    accept     = (state_q == S_IDLE) && in_valid;
    last_chunk = (idx_q == LAST_IDX);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; any unreachable encoding falls back to IDLE
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = in_valid   ? S_CALC : S_IDLE;
      S_CALC:  state_d = last_chunk ? S_DONE : S_CALC;
      S_DONE:  state_d = out_ready  ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath: latch operands on accept, add one chunk per CALC cycle, commit at the end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      cflag_q  <= 1'b0;
`ifdef ULA_SEQ_ACC_EN
      last_q   <= '0;
`endif
    end else if (accept) begin
      // Subtraction is A' + ~B' + 1; inversion happens after extension
      a_q     <= a_src;
      b_q     <= operation ? ~b_ext : b_ext;
      carry_q <= operation;
      idx_q   <= '0;
      sum_q   <= '0;
    end else if (state_q == S_CALC) begin
      sum_q   <= sum_nxt;
      carry_q <= csum[CHUNK];
      idx_q   <= idx_q + 1'b1;
      if (last_chunk) begin
        result_q <= sum_nxt;
        sign_q   <= sum_nxt[OUT_WIDTH-1];
        zero_q   <= (sum_nxt == '0);
        cflag_q  <= csum[CHUNK];
`ifdef ULA_SEQ_ACC_EN
        last_q   <= sum_nxt;
`endif
      end
    end
  end

  assign result     = result_q;
  assign sign_flag  = sign_q;
  assign zero_flag  = zero_q;
  assign carry_flag = cflag_q;

endmodule

// File: tb/tb_ula_seq_adder.sv
// Directed testbench for ula_seq_adder (default parameters).
module tb_ula_seq_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        operation;
  logic        in_acc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        sign_flag, zero_flag, carry_flag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ula_seq_adder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .operation  (operation),
`ifdef ULA_SEQ_ACC_EN
    .in_acc     (in_acc),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .sign_flag  (sign_flag),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag)
  );

  // Present one operation for a single edge, then count edges until out_valid.
  // lat = -1 when out_valid never arrives within the budget.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic top,
                        input logic tacc, output int lat);
    a = ta; b = tb; operation = top; in_acc = tacc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'hA5; b = 8'h5A; operation = ~top; in_acc = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; operation = 1'b0;
    in_acc = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if ({result, sign_flag, zero_flag, carry_flag} !== 19'h0) begin
      fails++; $display("FAIL reset_outputs got %h %b%b%b want 0", result, sign_flag, zero_flag, carry_flag);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // 0x7F + 0x01 with out_ready held high in advance: DONE lasts one cycle
  task automatic test_add();
    int lat;
    out_ready = 1'b1;
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL add_latency got %0d want 4", lat); end
    tests++; if (result !== 16'h0080) begin fails++; $display("FAIL add_result got %h want 0080", result); end
    tests++; if ({sign_flag, zero_flag, carry_flag} !== 3'b000) begin
      fails++; $display("FAIL add_flags got %b%b%b want 000", sign_flag, zero_flag, carry_flag);
    end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL add_done_one_cycle got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_sub_zero();
    int lat;
    run_op(8'h05, 8'h05, 1'b1, 1'b0, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL subz_latency got %0d want 4", lat); end
    tests++; if (result !== 16'h0000) begin fails++; $display("FAIL subz_result got %h want 0000", result); end
    tests++; if ({sign_flag, zero_flag, carry_flag} !== 3'b011) begin
      fails++; $display("FAIL subz_flags got %b%b%b want 011", sign_flag, zero_flag, carry_flag);
    end
    consume();
  endtask

  // Most-negative minus most-positive, then two negatives summed
  task automatic test_sub_neg();
    int lat;
    run_op(8'h80, 8'h7F, 1'b1, 1'b0, lat);
    tests++; if (result !== 16'hFF01) begin fails++; $display("FAIL subn_result got %h want ff01", result); end
    tests++; if ({sign_flag, zero_flag, carry_flag} !== 3'b101) begin
      fails++; $display("FAIL subn_flags got %b%b%b want 101", sign_flag, zero_flag, carry_flag);
    end
    consume();
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, lat);
    tests++; if (result !== 16'hFFFE) begin fails++; $display("FAIL addneg_result got %h want fffe", result); end
    tests++; if ({sign_flag, zero_flag, carry_flag} !== 3'b101) begin
      fails++; $display("FAIL addneg_flags got %b%b%b want 101", sign_flag, zero_flag, carry_flag);
    end
    consume();
  endtask

  // Hold DONE with out_ready low while in_valid pulses with new operands
  task automatic test_backpressure();
    int lat;
    int bad;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
    tests++; if (result !== 16'h0046) begin fails++; $display("FAIL bp_result got %h want 0046", result); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      a = 8'h01; b = 8'h01; operation = 1'b0; in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h0046) bad++;
    end
    in_valid = 1'b0;
    tests++; if (bad !== 0) begin fails++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    consume();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
    repeat (5) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0046) begin
      fails++; $display("FAIL bp_no_accept got ir=%b ov=%b res=%h want ir=1 ov=0 res=0046", in_ready, out_valid, result);
    end
  endtask

  // Reset during chunk 2 aborts the operation; the next one runs cleanly
  task automatic test_reset_mid();
    int lat;
    a = 8'h11; b = 8'h22; operation = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000) begin
      fails++; $display("FAIL rstmid got ir=%b ov=%b res=%h want ir=1 ov=0 res=0000", in_ready, out_valid, result);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_no_valid got %b want 0", out_valid); end
    run_op(8'h03, 8'h04, 1'b0, 1'b0, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL rstmid_latency got %0d want 4", lat); end
    tests++; if (result !== 16'h0007) begin fails++; $display("FAIL rstmid_result got %h want 0007", result); end
    consume();
  endtask

`ifdef ULA_SEQ_ACC_EN
  task automatic test_acc();
    int lat;
    run_op(8'h10, 8'h20, 1'b0, 1'b0, lat);
    tests++; if (result !== 16'h0030) begin fails++; $display("FAIL acc_first got %h want 0030", result); end
    consume();
    run_op(8'h77, 8'h05, 1'b0, 1'b1, lat);
    tests++; if (result !== 16'h0035) begin fails++; $display("FAIL acc_add got %h want 0035", result); end
    consume();
    run_op(8'h77, 8'h40, 1'b1, 1'b1, lat);
    tests++; if (result !== 16'hFFF5 || sign_flag !== 1'b1) begin
      fails++; $display("FAIL acc_sub got %h s=%b want fff5 s=1", result, sign_flag);
    end
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_sub_neg();
    test_backpressure();
    test_reset_mid();
`ifdef ULA_SEQ_ACC_EN
    test_acc();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
